// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: FSM encoding, slave select codes
// and the default frame width used by the existing 6-bit master.
package spi_pkg;

  localparam int DEFAULT_DATA_W = 6;
  localparam int SS_W           = 3;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = STATE_IDLE,
    SHIFT = STATE_SHIFT
  } state_t;

  localparam logic [SS_W-1:0] SS_SLAVE_1 = 3'b000;
  localparam logic [SS_W-1:0] SS_SLAVE_2 = 3'b001;
  localparam logic [SS_W-1:0] SS_SLAVE_3 = 3'b010;

endpackage

// File: rtl/spi_slave_txbuf.sv
// One-entry transmit buffer: ready/load handshake, same-edge bypass into the
// shifter at frame start, and a sticky underrun flag.
module spi_slave_txbuf
  import spi_pkg::*;
#(
  parameter int                DATA_W     = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] TX_DEFAULT = '0
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] tx_word,
  output logic              underrun
);

  logic [DATA_W-1:0] tx_buf_reg, tx_buf_next;
  logic              tx_ready_reg, tx_ready_next;
  logic              underrun_reg, underrun_next;
  logic              load_accept;

  assign load_accept = tx_load && tx_ready_reg;

  // A load accepted on the frame-start edge goes straight to the shifter.
  assign tx_word = load_accept ? tx_data : tx_buf_reg;

  always_comb begin
    tx_buf_next   = tx_buf_reg;
    tx_ready_next = tx_ready_reg;
    underrun_next = underrun_reg;
    if (load_accept) begin
      tx_buf_next   = tx_data;
      tx_ready_next = 1'b0;
    end
    if (frame_start) begin
      // Buffer consumed: ready again even when the bypass was taken.
      tx_ready_next = 1'b1;
      if (tx_ready_reg && !load_accept) begin
        underrun_next = 1'b1;
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      tx_buf_reg   <= TX_DEFAULT;
      tx_ready_reg <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      tx_buf_reg   <= tx_buf_next;
      tx_ready_reg <= tx_ready_next;
      underrun_reg <= underrun_next;
    end
  end

  assign tx_ready = tx_ready_reg;
  assign underrun = underrun_reg;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: MSB-first full-duplex frame of DATA_W bits while ss matches
// SLAVE_ID, received word presented with a one-cycle valid pulse.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                DATA_W     = DEFAULT_DATA_W,
  parameter logic [SS_W-1:0]   SLAVE_ID   = SS_SLAVE_1,
  parameter logic [DATA_W-1:0] TX_DEFAULT = '0
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic [SS_W-1:0]   ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              underrun
);

  localparam int               CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [DATA_W-1:0] tx_sh_reg, tx_sh_next;
  logic [DATA_W-1:0] rx_sh_reg, rx_sh_next;
  logic [DATA_W-1:0] rx_data_reg, rx_data_next;
  logic              rx_valid_reg, rx_valid_next;

  logic              selected;
  logic              frame_start;
  logic [DATA_W-1:0] tx_word;
  logic [DATA_W-1:0] rx_shifted;
  logic [DATA_W-1:0] tx_shifted;

  assign selected = (ss == SLAVE_ID);

  spi_slave_txbuf #(
    .DATA_W     (DATA_W),
    .TX_DEFAULT (TX_DEFAULT)
  ) u_txbuf (
    .sclk        (sclk),
    .reset       (reset),
    .frame_start (frame_start),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .tx_ready    (tx_ready),
    .tx_word     (tx_word),
    .underrun    (underrun)
  );

  // One-bit left shifts: mosi enters the receiver LSB, zero fills the transmitter.
  assign rx_shifted[0] = mosi;
  assign tx_shifted[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 1; gi < DATA_W; gi++) begin : g_shift
      assign rx_shifted[gi] = rx_sh_reg[gi-1];
      assign tx_shifted[gi] = tx_sh_reg[gi-1];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    tx_sh_next    = tx_sh_reg;
    rx_sh_next    = rx_sh_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    frame_start   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (selected) begin
          frame_start = 1'b1;
          tx_sh_next  = tx_word;
          count_next  = '0;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (!selected) begin
          // Deselect aborts silently; the consumed tx word is not restored.
          state_next = IDLE;
          count_next = '0;
        end else begin
          rx_sh_next = rx_shifted;
          tx_sh_next = tx_shifted;
          if (count_reg == CNT_LAST) begin
            rx_data_next  = rx_shifted;
            rx_valid_next = 1'b1;
            state_next    = IDLE;
            count_next    = '0;
          end else begin
            count_next = count_reg + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      tx_sh_reg    <= '0;
      rx_sh_reg    <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      tx_sh_reg    <= tx_sh_next;
      rx_sh_reg    <= rx_sh_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
    end
  end

  assign miso     = (state_reg == SHIFT && selected) ? tx_sh_reg[DATA_W-1] : 1'b0;
  assign busy     = (state_reg == SHIFT);
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Directed plus randomized frames for spi_slave, checked against a word-level
// model of the tx buffer, underrun flag and received data.
module tb_spi_slave;

  localparam int         W      = 6;
  localparam logic [2:0] ID     = 3'b000;
  localparam logic [2:0] OTHER  = 3'b001;
  localparam logic [W-1:0] TXDEF = 6'b000000;

  logic         sclk;
  logic         reset;
  logic [2:0]   ss;
  logic         mosi;
  logic         miso;
  logic [W-1:0] tx_data;
  logic         tx_load;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
  logic         underrun;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [W-1:0] m_buf;
  bit           m_ready;
  bit           m_underrun;
  logic [W-1:0] m_rx;

  spi_slave #(
    .DATA_W     (W),
    .SLAVE_ID   (ID),
    .TX_DEFAULT (TXDEF)
  ) dut (
    .sclk     (sclk),
    .reset    (reset),
    .ss       (ss),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .underrun (underrun)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_buf      = TXDEF;
    m_ready    = 1'b0;
    m_underrun = 1'b0;
    m_rx       = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".rx_valid"}, 32'(rx_valid), 32'(0));
    check({tag, ".rx_data"},  32'(rx_data),  32'(0));
    check({tag, ".busy"},     32'(busy),     32'(0));
    check({tag, ".miso"},     32'(miso),     32'(0));
    check({tag, ".tx_ready"}, 32'(tx_ready), 32'(0));
    check({tag, ".underrun"}, 32'(underrun), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge sclk);
    reset = 1'b1;
    @(negedge sclk);
    reset = 1'b0;
    model_reset();
    check_reset_state("reset");
    $display("reset: outputs at reset values");
  endtask

  // Offer a word to the tx buffer; accepted only when the model says ready.
  task automatic load_word(input logic [W-1:0] d);
    @(negedge sclk);
    tx_load = 1'b1;
    tx_data = d;
    if (m_ready) begin
      m_buf   = d;
      m_ready = 1'b0;
    end
    @(negedge sclk);
    tx_load = 1'b0;
    check("load.tx_ready", 32'(tx_ready), 32'(m_ready));
    $display("load %b: tx_ready=%0b buf=%b", d, tx_ready, m_buf);
  endtask

  // One frame. abort_at / reset_at: bit index at which to deselect / reset (-1: never).
  task automatic run_frame(input logic [W-1:0] rx_word, input bit load_now,
                           input logic [W-1:0] load_val, input int abort_at,
                           input int reset_at);
    logic [W-1:0] exp_tx;
    bit           acc;
    @(negedge sclk);
    ss      = ID;
    tx_load = load_now;
    tx_data = load_val;
    mosi    = 1'b0;
    acc     = load_now && m_ready;
    exp_tx  = acc ? load_val : m_buf;
    if (acc) m_buf = load_val;
    if (m_ready && !acc) m_underrun = 1'b1;
    m_ready = 1'b1;
    @(negedge sclk);
    tx_load = 1'b0;
    check("start.busy",     32'(busy),     32'(1));
    check("start.tx_ready", 32'(tx_ready), 32'(1));
    check("start.underrun", 32'(underrun), 32'(m_underrun));
    check("start.miso",     32'(miso),     32'(exp_tx[W-1]));
    for (int i = 0; i < W; i++) begin
      if (i == abort_at) begin
        ss = 3'b011;
        #1;
        check("abort.miso", 32'(miso), 32'(0));
        @(negedge sclk);
        check("abort.busy",     32'(busy),     32'(0));
        check("abort.rx_valid", 32'(rx_valid), 32'(0));
        check("abort.rx_data",  32'(rx_data),  32'(m_rx));
        ss = OTHER;
        $display("frame aborted after %0d bits: rx_data=%b", i, rx_data);
        return;
      end
      if (i == reset_at) begin
        reset = 1'b1;
        @(negedge sclk);
        reset = 1'b0;
        ss    = OTHER;
        model_reset();
        check_reset_state("midreset");
        $display("frame reset after %0d bits", i);
        return;
      end
      mosi = rx_word[W-1-i];
      @(negedge sclk);
      if (i < W - 1) begin
        check("shift.miso",     32'(miso),     32'(exp_tx[W-2-i]));
        check("shift.rx_valid", 32'(rx_valid), 32'(0));
      end
    end
    m_rx = rx_word;
    check("end.rx_valid", 32'(rx_valid), 32'(1));
    check("end.rx_data",  32'(rx_data),  32'(m_rx));
    check("end.busy",     32'(busy),     32'(0));
    check("end.miso",     32'(miso),     32'(0));
    ss = OTHER;
    @(negedge sclk);
    check("post.rx_valid", 32'(rx_valid), 32'(0));
    check("post.underrun", 32'(underrun), 32'(m_underrun));
    $display("frame tx=%b rx=%b underrun=%0b", exp_tx, rx_data, underrun);
  endtask

  initial begin
    reset   = 1'b1;
    ss      = OTHER;
    mosi    = 1'b0;
    tx_data = '0;
    tx_load = 1'b0;
    model_reset();

    do_reset();

    // Default buffer counts as loaded: no underrun on the first frame.
    run_frame(6'b101101, 1'b0, '0, -1, -1);

    load_word(6'b110010);
    run_frame(6'b010011, 1'b0, '0, -1, -1);

    // No reload: word repeats and underrun sets.
    run_frame(6'b111000, 1'b0, '0, -1, -1);
    check("sticky.underrun", 32'(underrun), 32'(1));

    run_frame(6'b000111, 1'b0, '0, 3, -1);
    run_frame(6'b100110, 1'b0, '0, -1, -1);

    // Other slave selected for 10 cycles.
    ss = OTHER;
    for (int c = 0; c < 10; c++) begin
      @(negedge sclk);
      check("other.busy",     32'(busy),     32'(0));
      check("other.miso",     32'(miso),     32'(0));
      check("other.rx_valid", 32'(rx_valid), 32'(0));
    end
    $display("other slave selected 10 cycles: idle");

    // Load on the frame-start edge bypasses the buffer.
    run_frame(6'b011010, 1'b1, 6'b011111, -1, -1);

    // Load while not ready is ignored.
    load_word(6'b101010);
    load_word(6'b010101);
    run_frame(6'b110011, 1'b0, '0, -1, -1);

    run_frame(6'b111111, 1'b0, '0, -1, 4);
    run_frame(6'b001001, 1'b0, '0, -1, -1);

    for (int n = 0; n < 40; n++) begin
      int abort_at;
      if ($urandom_range(0, 2) == 0) load_word(W'($urandom));
      if ($urandom_range(0, 3) == 0) load_word(W'($urandom));
      abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      run_frame(W'($urandom), 1'($urandom_range(0, 1)), W'($urandom), abort_at, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
